spi_command_burst_slave: RTL and testbench
==========================================

# spi_command_burst_slave

Parametrised SPI target: second generation of the PicoView test-harness SPI command interface. Each transaction carries one command word followed by a burst of up to MAX_WORDS data words, full duplex. SPI mode (CPOL/CPHA), bit order, command width and data width are all parameters. The block sits between the external SPI pins and the test controller logic. All pins are resynchronised into `clk`, and partial transfers are reported instead of being silently dropped.

## Interface
Parameters:
- COMMAND_WIDTH, 8: command word bits.
- WORD_WIDTH, 32: data word bits.
- MAX_WORDS, 1: maximum data words per transaction (≥1).
- CPOL, 0: SCK idle level.
- CPHA, 0: 0 = sample on leading edge, 1 = sample on trailing edge.
- LSB_FIRST, 1: 1 = first bit on the wire is bit 0.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- sck  in  1  SPI clock, asynchronous to clk.
- sdi  in  1  SPI data in, asynchronous to clk.
- cs  in  1  chip select, active low, asynchronous to clk.
- sdo  out  1  SPI data out, registered.
- command  out  COMMAND_WIDTH  last received command.
- command_ready  out  1  one-cycle pulse when command is valid.
- word_to_output  in  WORD_WIDTH  response word, sampled in STAGE.
- word_received  out  WORD_WIDTH  last received data word.
- word_rx_complete  out  1  one-cycle pulse when word_received is valid.
- word_index  out  $clog2(MAX_WORDS+1)  index of the word being transferred, or of the one just completed.
- aborted  out  1  one-cycle pulse when cs rises mid-command or mid-word.
- overrun  out  1  one-cycle pulse on a sample edge after MAX_WORDS words.

## Operation
- Pin synchronisation: sck, sdi and cs each pass through a 2-flop synchroniser.
- Edge detection: edges are taken from the synchronised sck. The leading edge is rising if CPOL=0, falling if CPOL=1.
- Sample and drive edges: the sample edge is the leading edge if CPHA=0, otherwise the trailing edge. The drive edge is the opposite edge.
- Bit counter: one counter counts sample edges within the current word. It clears on entry to CMD and to DATA.
- Bit order: with LSB_FIRST=1, the first received bit lands in bit 0. Otherwise it lands in the MSB. Transmit order follows the same rule.
- States: RESET, STALL, IDLE, CMD, STAGE, DATA.
- RESET: goes to STALL on the next clk.
- STALL: sdo=0. Goes to IDLE when the synchronised cs=1. This prevents joining a transfer already in progress.
- IDLE: goes to CMD when cs=0. word_index is cleared.
- CMD: shifts sdi in on each sample edge. After COMMAND_WIDTH bits, the bits are copied to `command`, command_ready pulses, and the FSM goes to STAGE.
- STAGE (one cycle):
  - Loads word_to_output into the tx shift register.
  - sdo is set to the first tx bit.
  - Goes to DATA.
- DATA:
  - Sample edge: shifts sdi into the rx register and advances the tx pointer.
  - Drive edge: sdo takes the current tx bit. With CPHA=1, the first drive edge re-presents bit 0.
- End of word: after WORD_WIDTH sample edges, word_received is written and word_rx_complete pulses. If word_index+1 < MAX_WORDS, word_index increments and the FSM returns to STAGE. Otherwise the FSM goes to STALL.
- cs rising in CMD or DATA with bit counter ≠0: aborted pulses, nothing else is published, and the FSM goes to IDLE.
- cs rising in CMD or DATA with bit counter =0: clean end of transaction; the FSM goes to IDLE with no pulse.
- Sample edge in STALL while cs=0: overrun pulses, and the edge is otherwise ignored.

## Timing
- Reset values: every output is 0 (sdo, command, command_ready, word_received, word_rx_complete, word_index, aborted, overrun). The state register resets to RESET.
- Reset mid-transfer: state and outputs return to reset values immediately, and the rest of that transaction is ignored.
- Pin-to-detect latency: a pin edge is detected 3 clk cycles after it occurs (2 synchroniser stages plus 1 edge-detect stage).
- Command latency: command_ready asserts the cycle after the final command sample edge is detected.
- Word latency: word_rx_complete asserts the cycle after the final data sample edge is detected. word_received is valid in that same cycle.
- word_to_output capture: sampled exactly one cycle after command_ready, and one cycle after each non-final word_rx_complete.
- SCK constraint: each SCK phase (high or low) must last at least 4 clk cycles. Under that constraint no sample edge coincides with STAGE.
- Simultaneous cs rise and final sample edge: the word completes first (word_rx_complete pulses, no aborted pulse), then the FSM goes to IDLE.
- Pulse outputs: each pulse is exactly one cycle wide and never coincides with another pulse of the same kind.

## Test plan
- Mode 0, defaults: send command 0xA5, then data 0x12345678, with word_to_output=0xCAFEF00D. Required: command=0xA5, command_ready pulses once, word_received=0x12345678, and the sdo bitstream LSB-first reads 0xCAFEF00D.
- MAX_WORDS=3, mode 3 (CPOL=1, CPHA=1), LSB_FIRST=0: one cs-low burst of 3 words, each with a distinct response. Required: 3 word_rx_complete pulses with word_index 0,1,2, and each response appears MSB-first on sdo.
- Abort: cs rises after 12 data bits. Required: aborted pulses once, word_rx_complete never pulses, and the next transaction decodes normally.
- Overrun: MAX_WORDS=1 with 40 extra SCK cycles sent. Required: 40 overrun pulses, word_received unchanged, and sdo=0.
- Startup: release reset_n while cs=0 and SCK is toggling. Required: no command_ready until cs has gone high and then low.
- Async reset: assert reset_n mid-command. Required: all outputs become 0 immediately, and a following clean transaction decodes correctly.

Source files
------------

// File: rtl/spi_command_burst_slave_if.sv
// Pin and controller-side bundle for the SPI command/burst target.
interface spi_command_burst_slave_if #(
    parameter int unsigned COMMAND_WIDTH = 8,
    parameter int unsigned WORD_WIDTH    = 32,
    parameter int unsigned MAX_WORDS     = 1
);
    localparam int unsigned INDEX_WIDTH = $clog2(MAX_WORDS + 1);

    logic                     sck;
    logic                     sdi;
    logic                     cs;
    logic                     sdo;
    logic [COMMAND_WIDTH-1:0] command;
    logic                     command_ready;
    logic [WORD_WIDTH-1:0]    word_to_output;
    logic [WORD_WIDTH-1:0]    word_received;
    logic                     word_rx_complete;
    logic [INDEX_WIDTH-1:0]   word_index;
    logic                     aborted;
    logic                     overrun;

    // Target side: pins and response word in, results out
    modport slave (
        input  sck, sdi, cs, word_to_output,
        output sdo, command, command_ready, word_received, word_rx_complete,
               word_index, aborted, overrun
    );

    // Driver side: SPI master plus test controller
    modport master (
        output sck, sdi, cs, word_to_output,
        input  sdo, command, command_ready, word_received, word_rx_complete,
               word_index, aborted, overrun
    );
endinterface

// File: rtl/spi_command_burst_slave.sv
// SPI target: one command word followed by a burst of up to MAX_WORDS full-duplex
// data words. All pins are resynchronised into clk; partial transfers are flagged.
module spi_command_burst_slave #(
    parameter int unsigned COMMAND_WIDTH = 8,
    parameter int unsigned WORD_WIDTH    = 32,
    parameter int unsigned MAX_WORDS     = 1,
    parameter bit          CPOL          = 1'b0,
    parameter bit          CPHA          = 1'b0,
    parameter bit          LSB_FIRST     = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    spi_command_burst_slave_if.slave bus
);
    localparam int unsigned INDEX_WIDTH = $clog2(MAX_WORDS + 1);
    localparam int unsigned MAX_BITS    = (COMMAND_WIDTH > WORD_WIDTH) ? COMMAND_WIDTH : WORD_WIDTH;
    localparam int unsigned COUNT_WIDTH = $clog2(MAX_BITS + 1);

    localparam logic [2:0] ST_RESET = 3'd0;
    localparam logic [2:0] ST_STALL = 3'd1;
    localparam logic [2:0] ST_IDLE  = 3'd2;
    localparam logic [2:0] ST_CMD   = 3'd3;
    localparam logic [2:0] ST_STAGE = 3'd4;
    localparam logic [2:0] ST_DATA  = 3'd5;

    // sck resets to its idle level so reset release does not fake an edge
    localparam logic [2:0] PIN_RST = {2'b00, CPOL};

    // Pin pipeline, packed as {cs, sdi, sck}
    logic [2:0] meta_q, meta_d, sync_q, sync_d;
    logic       sck_prev_q, sck_prev_d;
    logic       sdi_q, sdi_d;
    logic       cs_q, cs_d;
    logic       sample_edge_q, sample_edge_d;
    logic       drive_edge_q, drive_edge_d;
    logic       sck_rise, sck_fall, lead_edge, trail_edge;

    // FSM and datapath
    logic [2:0]               state_q, state_d;
    logic [COUNT_WIDTH-1:0]   bit_cnt_q, bit_cnt_d;
    logic [COMMAND_WIDTH-1:0] cmd_shift_q, cmd_shift_d, cmd_shift_nx;
    logic [WORD_WIDTH-1:0]    rx_shift_q, rx_shift_d, rx_shift_nx;
    logic [WORD_WIDTH-1:0]    tx_shift_q, tx_shift_d, tx_shift_nx;
    logic                     tx_bit, stage_bit, cmd_last, word_last, more_words;

    // Registered outputs
    logic                     sdo_q, sdo_d;
    logic [COMMAND_WIDTH-1:0] command_q, command_d;
    logic                     command_ready_q, command_ready_d;
    logic [WORD_WIDTH-1:0]    word_received_q, word_received_d;
    logic                     word_rx_complete_q, word_rx_complete_d;
    logic [INDEX_WIDTH-1:0]   word_index_q, word_index_d;
    logic                     aborted_q, aborted_d;
    logic                     overrun_q, overrun_d;

    // Two-stage synchroniser followed by edge classification per SPI mode
    always_comb begin
        meta_d        = {bus.cs, bus.sdi, bus.sck};
        sync_d        = meta_q;
        sck_prev_d    = sync_q[0];
        sdi_d         = sync_q[1];
        cs_d          = sync_q[2];
        sck_rise      = sync_q[0] & ~sck_prev_q;
        sck_fall      = ~sync_q[0] & sck_prev_q;
        lead_edge     = CPOL ? sck_fall : sck_rise;
        trail_edge    = CPOL ? sck_rise : sck_fall;
        sample_edge_d = CPHA ? trail_edge : lead_edge;
        drive_edge_d  = CPHA ? lead_edge : trail_edge;
    end

    // Pin pipeline registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q        <= PIN_RST;
            sync_q        <= PIN_RST;
            sck_prev_q    <= CPOL;
            sdi_q         <= 1'b0;
            cs_q          <= 1'b0;
            sample_edge_q <= 1'b0;
            drive_edge_q  <= 1'b0;
        end else begin
            meta_q        <= meta_d;
            sync_q        <= sync_d;
            sck_prev_q    <= sck_prev_d;
            sdi_q         <= sdi_d;
            cs_q          <= cs_d;
            sample_edge_q <= sample_edge_d;
            drive_edge_q  <= drive_edge_d;
        end
    end

    // Shift-register helpers; a full word of shifts leaves the first bit in place
    always_comb begin
        cmd_shift_nx = LSB_FIRST ? {sdi_q, cmd_shift_q[COMMAND_WIDTH-1:1]}
                                 : {cmd_shift_q[COMMAND_WIDTH-2:0], sdi_q};
        rx_shift_nx  = LSB_FIRST ? {sdi_q, rx_shift_q[WORD_WIDTH-1:1]}
                                 : {rx_shift_q[WORD_WIDTH-2:0], sdi_q};
        tx_shift_nx  = LSB_FIRST ? {1'b0, tx_shift_q[WORD_WIDTH-1:1]}
                                 : {tx_shift_q[WORD_WIDTH-2:0], 1'b0};
        tx_bit       = LSB_FIRST ? tx_shift_q[0] : tx_shift_q[WORD_WIDTH-1];
        stage_bit    = LSB_FIRST ? bus.word_to_output[0] : bus.word_to_output[WORD_WIDTH-1];
        cmd_last     = (bit_cnt_q == COUNT_WIDTH'(COMMAND_WIDTH - 1));
        word_last    = (bit_cnt_q == COUNT_WIDTH'(WORD_WIDTH - 1));
        more_words   = ((32'(word_index_q) + 32'd1) < 32'(MAX_WORDS));
    end

    // Next-state and output logic
    always_comb begin
        state_d            = state_q;
        bit_cnt_d          = bit_cnt_q;
        cmd_shift_d        = cmd_shift_q;
        rx_shift_d         = rx_shift_q;
        tx_shift_d         = tx_shift_q;
        sdo_d              = sdo_q;
        command_d          = command_q;
        command_ready_d    = 1'b0;
        word_received_d    = word_received_q;
        word_rx_complete_d = 1'b0;
        word_index_d       = word_index_q;
        aborted_d          = 1'b0;
        overrun_d          = 1'b0;

        case (state_q)
            ST_RESET: begin
                state_d = ST_STALL;
            end
            ST_STALL: begin
                sdo_d = 1'b0;
                if (cs_q) begin
                    state_d = ST_IDLE;
                end else if (sample_edge_q) begin
                    overrun_d = 1'b1;
                end
            end
            ST_IDLE: begin
                word_index_d = '0;
                if (!cs_q) begin
                    bit_cnt_d = '0;
                    state_d   = ST_CMD;
                end
            end
            ST_CMD: begin
                if (sample_edge_q) begin
                    cmd_shift_d = cmd_shift_nx;
                    bit_cnt_d   = bit_cnt_q + COUNT_WIDTH'(1);
                end
                if (sample_edge_q && cmd_last) begin
                    command_d       = cmd_shift_nx;
                    command_ready_d = 1'b1;
                    bit_cnt_d       = '0;
                    state_d         = cs_q ? ST_IDLE : ST_STAGE;
                end else if (cs_q) begin
                    aborted_d = (bit_cnt_q != '0) || sample_edge_q;
                    state_d   = ST_IDLE;
                end
            end
            ST_STAGE: begin
                // Index advances here so the completion pulse still shows the finished word
                if (word_rx_complete_q) begin
                    word_index_d = word_index_q + INDEX_WIDTH'(1);
                end
                tx_shift_d = bus.word_to_output;
                sdo_d      = stage_bit;
                bit_cnt_d  = '0;
                state_d    = ST_DATA;
            end
            ST_DATA: begin
                if (drive_edge_q) begin
                    sdo_d = tx_bit;
                end
                if (sample_edge_q) begin
                    rx_shift_d = rx_shift_nx;
                    tx_shift_d = tx_shift_nx;
                    bit_cnt_d  = bit_cnt_q + COUNT_WIDTH'(1);
                end
                // Final sample edge wins over a simultaneous cs release
                if (sample_edge_q && word_last) begin
                    word_received_d    = rx_shift_nx;
                    word_rx_complete_d = 1'b1;
                    bit_cnt_d          = '0;
                    if (cs_q) begin
                        state_d = ST_IDLE;
                    end else if (more_words) begin
                        state_d = ST_STAGE;
                    end else begin
                        state_d = ST_STALL;
                    end
                end else if (cs_q) begin
                    aborted_d = (bit_cnt_q != '0) || sample_edge_q;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_STALL;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q            <= ST_RESET;
            bit_cnt_q          <= '0;
            cmd_shift_q        <= '0;
            rx_shift_q         <= '0;
            tx_shift_q         <= '0;
            sdo_q              <= 1'b0;
            command_q          <= '0;
            command_ready_q    <= 1'b0;
            word_received_q    <= '0;
            word_rx_complete_q <= 1'b0;
            word_index_q       <= '0;
            aborted_q          <= 1'b0;
            overrun_q          <= 1'b0;
        end else begin
            state_q            <= state_d;
            bit_cnt_q          <= bit_cnt_d;
            cmd_shift_q        <= cmd_shift_d;
            rx_shift_q         <= rx_shift_d;
            tx_shift_q         <= tx_shift_d;
            sdo_q              <= sdo_d;
            command_q          <= command_d;
            command_ready_q    <= command_ready_d;
            word_received_q    <= word_received_d;
            word_rx_complete_q <= word_rx_complete_d;
            word_index_q       <= word_index_d;
            aborted_q          <= aborted_d;
            overrun_q          <= overrun_d;
        end
    end

    assign bus.sdo              = sdo_q;
    assign bus.command          = command_q;
    assign bus.command_ready    = command_ready_q;
    assign bus.word_received    = word_received_q;
    assign bus.word_rx_complete = word_rx_complete_q;
    assign bus.word_index       = word_index_q;
    assign bus.aborted          = aborted_q;
    assign bus.overrun          = overrun_q;

endmodule

// File: tb/tb_spi_command_burst_slave.sv
// Directed bench: dut0 = defaults (mode 0, LSB first, 1 word),
// dut1 = mode 3, MSB first, 3-word bursts.
`timescale 1ns/1ps
module tb_spi_command_burst_slave;
    localparam int HP = 8;  // SCK half period in clk cycles

    logic clk = 1'b0;
    logic rst0_n;
    logic rst1_n;

    always #5 clk = ~clk;

    spi_command_burst_slave_if #(.COMMAND_WIDTH(8), .WORD_WIDTH(32), .MAX_WORDS(1)) if0 ();
    spi_command_burst_slave_if #(.COMMAND_WIDTH(8), .WORD_WIDTH(32), .MAX_WORDS(3)) if1 ();

    spi_command_burst_slave #(
        .COMMAND_WIDTH(8), .WORD_WIDTH(32), .MAX_WORDS(1),
        .CPOL(1'b0), .CPHA(1'b0), .LSB_FIRST(1'b1)
    ) dut0 (
        .clk(clk), .reset_n(rst0_n), .bus(if0.slave)
    );

    spi_command_burst_slave #(
        .COMMAND_WIDTH(8), .WORD_WIDTH(32), .MAX_WORDS(3),
        .CPOL(1'b1), .CPHA(1'b1), .LSB_FIRST(1'b0)
    ) dut1 (
        .clk(clk), .reset_n(rst1_n), .bus(if1.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Pulse counters and burst log, sampled mid-cycle
    int cr0 = 0, wrc0 = 0, ab0 = 0, ov0 = 0;
    int cr1 = 0, wrc1 = 0;
    logic [31:0] rx1_log  [4];
    logic [1:0]  idx1_log [4];

    always @(negedge clk) begin
        if (if0.command_ready)    cr0  <= cr0 + 1;
        if (if0.word_rx_complete) wrc0 <= wrc0 + 1;
        if (if0.aborted)          ab0  <= ab0 + 1;
        if (if0.overrun)          ov0  <= ov0 + 1;
        if (if1.command_ready)    cr1  <= cr1 + 1;
        if (if1.word_rx_complete) begin
            rx1_log[wrc1[1:0]]  <= if1.word_received;
            idx1_log[wrc1[1:0]] <= if1.word_index;
            wrc1 <= wrc1 + 1;
        end
    end

    logic [31:0] tx_words  [3];
    logic [31:0] rsp_words [3];
    logic [31:0] rx_words  [3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic put_sck(input int sel, input logic v);
        if (sel == 0) if0.sck = v; else if1.sck = v;
    endtask

    task automatic put_sdi(input int sel, input logic v);
        if (sel == 0) if0.sdi = v; else if1.sdi = v;
    endtask

    task automatic put_cs(input int sel, input logic v);
        if (sel == 0) if0.cs = v; else if1.cs = v;
    endtask

    task automatic put_w2o(input int sel, input logic [31:0] v);
        if (sel == 0) if0.word_to_output = v; else if1.word_to_output = v;
    endtask

    function automatic logic get_sdo(input int sel);
        return (sel == 0) ? if0.sdo : if1.sdo;
    endfunction

    // One SPI bit as master; sdo is captured just before the sample edge
    task automatic spi_bit(input int sel, input logic mosi, output logic miso);
        logic pol;
        logic pha;
        pol = (sel != 0);
        pha = (sel != 0);
        if (!pha) begin
            put_sdi(sel, mosi);
            wait_clk(HP);
            miso = get_sdo(sel);
            put_sck(sel, ~pol);
            wait_clk(HP);
            put_sck(sel, pol);
        end else begin
            put_sck(sel, ~pol);
            put_sdi(sel, mosi);
            wait_clk(HP);
            miso = get_sdo(sel);
            put_sck(sel, pol);
            wait_clk(HP);
        end
    endtask

    // Full transaction: command, nwords words (cut after abort_bits if >= 0), extra clocks
    task automatic spi_txn(input int sel, input logic [7:0] cmd, input int nwords,
                           input int abort_bits, input int extra, output logic extra_or);
        logic [7:0]  c;
        logic [31:0] s;
        logic [31:0] r;
        logic        b;
        logic        lsb;
        lsb      = (sel == 0);
        extra_or = 1'b0;
        put_w2o(sel, rsp_words[0]);
        put_cs(sel, 1'b0);
        wait_clk(HP);
        c = cmd;
        for (int i = 0; i < 8; i++) begin
            spi_bit(sel, lsb ? c[0] : c[7], b);
            c = lsb ? (c >> 1) : (c << 1);
        end
        for (int w = 0; w < nwords; w++) begin
            s = tx_words[w];
            r = '0;
            for (int i = 0; i < 32; i++) begin
                if (abort_bits >= 0 && i >= abort_bits) break;
                spi_bit(sel, lsb ? s[0] : s[31], b);
                s = lsb ? (s >> 1) : (s << 1);
                r = lsb ? {b, r[31:1]} : {r[30:0], b};
                if (i == 0 && w + 1 < nwords) put_w2o(sel, rsp_words[w + 1]);
            end
            rx_words[w] = r;
        end
        for (int e = 0; e < extra; e++) begin
            spi_bit(sel, 1'($urandom), b);
            extra_or = extra_or | b;
        end
        wait_clk(HP);
        put_cs(sel, 1'b1);
        wait_clk(4 * HP);
    endtask

    initial begin
        int   b_cr, b_wrc, b_ab, b_ov;
        logic eor;
        logic bit_dummy;

        if0.sck = 1'b0; if0.sdi = 1'b0; if0.cs = 1'b1; if0.word_to_output = '0;
        if1.sck = 1'b1; if1.sdi = 1'b0; if1.cs = 1'b1; if1.word_to_output = '0;
        rst0_n = 1'b0;
        rst1_n = 1'b0;
        wait_clk(3);

        // Reset state
        chk("rst_sdo",        32'(if0.sdo), 32'h0);
        chk("rst_command",    32'(if0.command), 32'h0);
        chk("rst_cmd_ready",  32'(if0.command_ready), 32'h0);
        chk("rst_word_rx",    if0.word_received, 32'h0);
        chk("rst_wrc",        32'(if0.word_rx_complete), 32'h0);
        chk("rst_word_index", 32'(if0.word_index), 32'h0);
        chk("rst_aborted",    32'(if0.aborted), 32'h0);
        chk("rst_overrun",    32'(if0.overrun), 32'h0);
        chk("rst1_word_idx",  32'(if1.word_index), 32'h0);

        rst0_n = 1'b1;
        rst1_n = 1'b1;
        wait_clk(10);

        // Mode 0 single word
        b_cr = cr0; b_wrc = wrc0; b_ab = ab0;
        tx_words[0] = 32'h12345678; rsp_words[0] = 32'hCAFEF00D;
        spi_txn(0, 8'hA5, 1, -1, 0, eor);
        chk("m0_command",    32'(if0.command), 32'hA5);
        chk("m0_cr_pulses",  32'(cr0 - b_cr), 32'd1);
        chk("m0_word_rx",    if0.word_received, 32'h12345678);
        chk("m0_wrc_pulses", 32'(wrc0 - b_wrc), 32'd1);
        chk("m0_sdo_word",   rx_words[0], 32'hCAFEF00D);
        chk("m0_no_abort",   32'(ab0 - b_ab), 32'd0);

        // Mode 3, MSB first, 3-word burst
        tx_words[0]  = 32'hDEADBEEF; tx_words[1]  = 32'h01234567; tx_words[2]  = 32'h89ABCDEF;
        rsp_words[0] = 32'hA1B2C3D4; rsp_words[1] = 32'h55AA33CC; rsp_words[2] = 32'h0F1E2D3C;
        spi_txn(1, 8'h3C, 3, -1, 0, eor);
        chk("m3_command",    32'(if1.command), 32'h3C);
        chk("m3_cr_pulses",  32'(cr1), 32'd1);
        chk("m3_wrc_pulses", 32'(wrc1), 32'd3);
        chk("m3_idx0",       32'(idx1_log[0]), 32'd0);
        chk("m3_idx1",       32'(idx1_log[1]), 32'd1);
        chk("m3_idx2",       32'(idx1_log[2]), 32'd2);
        chk("m3_rx0",        rx1_log[0], 32'hDEADBEEF);
        chk("m3_rx1",        rx1_log[1], 32'h01234567);
        chk("m3_rx2",        rx1_log[2], 32'h89ABCDEF);
        chk("m3_sdo0",       rx_words[0], 32'hA1B2C3D4);
        chk("m3_sdo1",       rx_words[1], 32'h55AA33CC);
        chk("m3_sdo2",       rx_words[2], 32'h0F1E2D3C);

        // Abort after 12 data bits, then a normal transaction
        b_cr = cr0; b_wrc = wrc0; b_ab = ab0;
        tx_words[0] = 32'hFFFF0000; rsp_words[0] = 32'h11112222;
        spi_txn(0, 8'h5A, 1, 12, 0, eor);
        chk("ab_pulses",     32'(ab0 - b_ab), 32'd1);
        chk("ab_no_wrc",     32'(wrc0 - b_wrc), 32'd0);
        chk("ab_cmd_pulse",  32'(cr0 - b_cr), 32'd1);
        chk("ab_word_kept",  if0.word_received, 32'h12345678);
        b_wrc = wrc0; b_ab = ab0;
        tx_words[0] = 32'h0BADC0DE; rsp_words[0] = 32'h600DF00D;
        spi_txn(0, 8'hC3, 1, -1, 0, eor);
        chk("post_ab_cmd",   32'(if0.command), 32'hC3);
        chk("post_ab_word",  if0.word_received, 32'h0BADC0DE);
        chk("post_ab_sdo",   rx_words[0], 32'h600DF00D);
        chk("post_ab_wrc",   32'(wrc0 - b_wrc), 32'd1);
        chk("post_ab_noab",  32'(ab0 - b_ab), 32'd0);

        // Overrun: 40 extra clocks after the only word
        b_ov = ov0; b_wrc = wrc0;
        tx_words[0] = 32'h13579BDF; rsp_words[0] = 32'hFFFFFFFF;
        spi_txn(0, 8'hE7, 1, -1, 40, eor);
        chk("ov_pulses",     32'(ov0 - b_ov), 32'd40);
        chk("ov_word_kept",  if0.word_received, 32'h13579BDF);
        chk("ov_wrc",        32'(wrc0 - b_wrc), 32'd1);
        chk("ov_sdo_quiet",  32'(eor), 32'd0);
        chk("ov_sdo_end",    32'(if0.sdo), 32'd0);

        // Async reset mid-command, then startup with cs low and SCK running
        b_cr = cr0; b_wrc = wrc0;
        put_cs(0, 1'b0);
        wait_clk(HP);
        for (int i = 0; i < 4; i++) spi_bit(0, 1'b1, bit_dummy);
        rst0_n = 1'b0;
        #1;
        chk("ar_command",    32'(if0.command), 32'h0);
        chk("ar_word_rx",    if0.word_received, 32'h0);
        chk("ar_sdo",        32'(if0.sdo), 32'h0);
        chk("ar_word_index", 32'(if0.word_index), 32'h0);
        chk("ar_cmd_ready",  32'(if0.command_ready), 32'h0);
        for (int i = 0; i < 6; i++) spi_bit(0, 1'($urandom), bit_dummy);
        rst0_n = 1'b1;
        for (int i = 0; i < 20; i++) spi_bit(0, 1'($urandom), bit_dummy);
        chk("su_no_cmd",     32'(cr0 - b_cr), 32'd0);
        chk("su_no_wrc",     32'(wrc0 - b_wrc), 32'd0);
        wait_clk(HP);
        put_cs(0, 1'b1);
        wait_clk(4 * HP);
        b_cr = cr0;
        tx_words[0] = 32'h2468ACE0; rsp_words[0] = 32'h7E57AB1E;
        spi_txn(0, 8'h81, 1, -1, 0, eor);
        chk("su_command",    32'(if0.command), 32'h81);
        chk("su_cr_pulses",  32'(cr0 - b_cr), 32'd1);
        chk("su_word_rx",    if0.word_received, 32'h2468ACE0);
        chk("su_sdo_word",   rx_words[0], 32'h7E57AB1E);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
